pc_ctrl_unit: RTL

//  Parametrised program-counter generator for the RV32 fetch stage; successor to the fixed 10-bit PC.

---
 rtl/pc_pkg.sv | 19 +
 rtl/pc_ras.sv | 65 ++++++
 rtl/pc_ctrl_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared encodings for the fetch-stage program-counter controller.
package pc_pkg;

    typedef enum logic [1:0] {
        MODE_NONE = 2'b00,
        MODE_BR   = 2'b01,
        MODE_JAL  = 2'b10,
        MODE_JALR = 2'b11
    } ctrl_mode_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_TRAP = 2'b10
    } pc_state_e;

    localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; compiled only when PC_RAS_EN is defined.
// A push onto a full stack silently replaces the oldest entry; a pop on empty does nothing.
`ifdef PC_RAS_EN
module pc_ras #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PC_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] ptr_inc, ptr_dec;

    // ptr_q is the next free slot; the top of stack sits one below it
    always_comb begin
        ptr_inc = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        ptr_dec = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - PTR_W'(1);
    end

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ptr_d = ptr_inc;
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop && (cnt_q != '0)) begin
            ptr_d = ptr_dec;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[ptr_q] <= push_data;
        end
    end

    assign top   = mem_q[ptr_dec];
    assign empty = (cnt_q == '0);

endmodule
`endif

// File: rtl/pc_ctrl_unit.sv
// RV32 fetch program-counter generator: PC+4 sequencing, branch/JAL/JALR redirect, stall,
// fetch handshake and misaligned-target trap. Optional return-address stack under PC_RAS_EN.
module pc_ctrl_unit
    import pc_pkg::*;
#(
    parameter int unsigned PC_W      = 10,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned IMM_W     = 21,
    parameter int unsigned RESET_VEC = 0,
    parameter int unsigned TRAP_VEC  = 'h3F0,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             fetch_ready,
    input  logic             ctrl_valid,
    input  logic [1:0]       ctrl_mode,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  ctrl_pc,
    input  logic [IMM_W-1:0] immediate,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic             trap_clear,
    output logic [PC_W-1:0]  pc_out,
    output logic             pc_valid,
    output logic [PC_W-1:0]  link_addr,
    output logic             misalign
`ifdef PC_RAS_EN
    ,
    output logic [PC_W-1:0]  ras_top,
    output logic             ras_empty
`endif
);

    localparam int unsigned EXT_W = (IMM_W > PC_W) ? IMM_W : PC_W;

    pc_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            pc_valid_q, pc_valid_d;
    logic            misalign_q, misalign_d;

    logic [EXT_W-1:0] imm_ext;
    logic [PC_W-1:0]  base;
    logic [PC_W-1:0]  sum;
    logic [PC_W-1:0]  target;
    logic             redirect;
    logic             is_jalr;
    logic             unused_bits;

    // Sign-extend first, then keep the low PC_W bits: arithmetic is modulo 2^PC_W
    assign imm_ext     = EXT_W'(signed'(immediate));
    assign unused_bits = ^{rs1_val, imm_ext};

    assign is_jalr  = (ctrl_mode == MODE_JALR);
    assign redirect = ctrl_valid && ((ctrl_mode == MODE_JAL) || is_jalr ||
                                     ((ctrl_mode == MODE_BR) && branch_taken));
    assign base     = is_jalr ? rs1_val[PC_W-1:0] : ctrl_pc;
    assign sum      = base + imm_ext[PC_W-1:0];
    assign target   = is_jalr ? {sum[PC_W-1:1], 1'b0} : sum;

    assign link_addr = ctrl_pc + PC_W'(INSN_BYTES);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        misalign_d = misalign_q;
        case (state_q)
            ST_BOOT: begin
                state_d    = ST_RUN;
                pc_valid_d = 1'b1;
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_d = target;
                    if (target[1:0] != 2'b00) begin
                        state_d    = ST_TRAP;
                        pc_valid_d = 1'b0;
                        misalign_d = 1'b1;
                    end
                end else if (pc_valid_q && fetch_ready && !stall) begin
                    pc_d = pc_q + PC_W'(INSN_BYTES);
                end
            end
            ST_TRAP: begin
                if (trap_clear) begin
                    state_d    = ST_RUN;
                    pc_d       = PC_W'(TRAP_VEC);
                    pc_valid_d = 1'b1;
                    misalign_d = 1'b0;
                end
            end
            default: begin
                state_d    = ST_BOOT;
                pc_d       = PC_W'(RESET_VEC);
                pc_valid_d = 1'b0;
                misalign_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= PC_W'(RESET_VEC);
            pc_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_out   = pc_q;
    assign pc_valid = pc_valid_q;
    assign misalign = misalign_q;

`ifdef PC_RAS_EN
    logic ras_push, ras_pop;

    // Only redirects taken while running touch the stack; the trap path does not undo them
    assign ras_push = (state_q == ST_RUN) && redirect && (ctrl_mode == MODE_JAL);
    assign ras_pop  = (state_q == ST_RUN) && redirect && is_jalr;

    pc_ras #(
        .PC_W  (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (link_addr),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    localparam int unsigned RAS_DEPTH_UNUSED = RAS_DEPTH;
`endif

endmodule
